// File: rtl/fc_layer_pkg.sv
// Shared types and arithmetic helpers for the parallel FC layer.
// State encoding, width helpers and output saturation/ReLU.
package fc_layer_pkg;

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUTPUT
    } state_t;

    localparam int MAXW = 64;

    function automatic int groups(input int m, input int p);
        return m / p;
    endfunction

    function automatic int acc_width(input int t, input int n);
        return 2 * t + $clog2(n) + 1;
    endfunction

    function automatic logic signed [MAXW-1:0] sat_relu(
        input logic signed [MAXW-1:0] acc,
        input int                     t,
        input bit                     relu
    );
        logic signed [MAXW-1:0] hi;
        logic signed [MAXW-1:0] lo;
        logic signed [MAXW-1:0] r;
        hi = (64'sd1 <<< (t - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        r  = acc;
        if (acc > hi) r = hi;
        else if (acc < lo) r = lo;
        if (relu && r < 0) r = '0;
        return r;
    endfunction

endpackage

// File: rtl/fc_layer_par_if.sv
// Valid/ready stream bundle for the FC layer ports.
// master drives valid/data, slave drives ready.
interface fc_layer_par_if #(
    parameter int T = 16
);
    logic         valid;
    logic         ready;
    logic [T-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/fc_mac_lane.sv
// One MAC lane: weight/bias ROM slice, product register, wide accumulator.
// Lane L owns rows L, L+P, L+2P, ...; result is saturated (and ReLU'd).
module fc_mac_lane
    import fc_layer_pkg::*;
#(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int P    = 1,
    parameter int T    = 16,
    parameter int L    = 0,
    parameter int RELU = 1,
    parameter logic [M*N*T-1:0] W_INIT = '0,
    parameter logic [M*T-1:0]   B_INIT = '0,
    localparam int G  = groups(M, P),
    localparam int GW = (G > 1) ? $clog2(G) : 1,
    localparam int JW = $clog2(N)
) (
    input  logic                clk,
    input  logic [GW-1:0]       g,
    input  logic [JW-1:0]       j,
    input  logic signed [T-1:0] x,
    input  logic                clr,
    input  logic                en,
    output logic signed [T-1:0] res
);
    localparam int AW = acc_width(T, N);
    localparam int WA = $clog2(G * N);

    logic signed [T-1:0]    w_rom [G*N];
    logic signed [T-1:0]    b_rom [G];
    logic [WA-1:0]          wa;
    logic signed [T-1:0]    w_q;
    logic signed [2*T-1:0]  prod_q;
    logic signed [AW-1:0]   acc_q;
    logic signed [T-1:0]    b;

    for (genvar gi = 0; gi < G; gi++) begin : g_rom
        for (genvar ji = 0; ji < N; ji++) begin : g_col
            assign w_rom[gi*N+ji] = W_INIT[((gi*P+L)*N+ji)*T +: T];
        end
        assign b_rom[gi] = B_INIT[(gi*P+L)*T +: T];
    end

    assign wa = WA'(int'(g) * N + int'(j));
    assign b  = b_rom[g];

    // ROM read, product and accumulate pipeline
    always_ff @(posedge clk) begin
        w_q    <= w_rom[wa];
        prod_q <= (2*T)'(w_q) * (2*T)'(x);
        if (clr) acc_q <= {{(AW-T){b[T-1]}}, b};
        else if (en) acc_q <= acc_q + {{(AW-2*T){prod_q[2*T-1]}}, prod_q};
    end

    assign res = T'(sat_relu({{(MAXW-AW){acc_q[AW-1]}}, acc_q}, T, RELU != 0));

endmodule

// File: rtl/fc_layer_par.sv
// Parametrised fully-connected layer y = act(W*x + b) with P MAC lanes.
// Streams x in, computes M/P groups of N+3 cycles, streams y out.
module fc_layer_par
    import fc_layer_pkg::*;
#(
    parameter int M    = 8,
    parameter int N    = 8,
    parameter int P    = 1,
    parameter int T    = 16,
    parameter int RELU = 1,
    parameter logic [M*N*T-1:0] W_INIT = '0,
    parameter logic [M*T-1:0]   B_INIT = '0
) (
    input  logic        clk,
    input  logic        reset,
    fc_layer_par_if.slave  s,
    fc_layer_par_if.master m
);
    localparam int G  = groups(M, P);
    localparam int GW = (G > 1) ? $clog2(G) : 1;
    localparam int JW = $clog2(N);
    localparam int CW = $clog2(N + 3);
    localparam int OW = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] C_NX   = CW'(N);
    localparam logic [CW-1:0] C_EN1  = CW'(N + 1);
    localparam logic [CW-1:0] C_WB   = CW'(N + 2);
    localparam logic [JW-1:0] K_LAST = JW'(N - 1);
    localparam logic [GW-1:0] G_LAST = GW'(G - 1);
    localparam logic [OW-1:0] O_LAST = OW'(M - 1);

    state_t              state_q, state_d;
    logic                sr_q, mv_q;
    logic [T-1:0]        dout_q;
    logic [JW-1:0]       k_q;
    logic [CW-1:0]       c_q;
    logic [GW-1:0]       g_q;
    logic [OW-1:0]       o_q;
    logic [T-1:0]        xmem [N];
    logic [T-1:0]        ybuf [M];
    logic signed [T-1:0] x_q;
    logic [JW-1:0]       xa;
    logic signed [T-1:0] res [P];
    logic                s_fire, m_fire, busy, clr, en, wb;

    assign s_fire  = s.valid && sr_q;
    assign m_fire  = mv_q && m.ready;
    assign busy    = (state_q == COMPUTE);
    assign clr     = busy && (c_q == '0);
    assign en      = busy && (c_q >= CW'(2)) && (c_q <= C_EN1);
    assign wb      = busy && (c_q == C_WB);
    assign xa      = (c_q < C_NX) ? c_q[JW-1:0] : '0;
    assign s.ready = sr_q;
    assign m.valid = mv_q;
    assign m.data  = dout_q;

    // Next-state: load x, compute all groups, drain y
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (s_fire && k_q == K_LAST) state_d = COMPUTE;
            COMPUTE: if (wb && g_q == G_LAST) state_d = OUTPUT;
            OUTPUT:  if (m_fire && o_q == O_LAST) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= LOAD;
        else state_q <= state_d;
    end

    // Handshake flags, counters and registered y output
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= 1'b0;
            mv_q   <= 1'b0;
            dout_q <= '0;
            k_q    <= '0;
            c_q    <= '0;
            g_q    <= '0;
            o_q    <= '0;
        end else begin
            sr_q <= (state_d == LOAD);
            if (s_fire) k_q <= (k_q == K_LAST) ? '0 : k_q + 1'b1;
            if (busy) begin
                if (wb) begin
                    c_q <= '0;
                    g_q <= (g_q == G_LAST) ? '0 : g_q + 1'b1;
                end else begin
                    c_q <= c_q + 1'b1;
                end
            end
            if (state_q == OUTPUT) begin
                if (!mv_q) begin
                    mv_q   <= 1'b1;
                    dout_q <= ybuf[o_q];
                end else if (m_fire) begin
                    if (o_q == O_LAST) begin
                        mv_q <= 1'b0;
                        o_q  <= '0;
                    end else begin
                        o_q    <= o_q + 1'b1;
                        dout_q <= ybuf[o_q + 1'b1];
                    end
                end
            end
        end
    end

    // X capture, broadcast X read, Y write-back
    always_ff @(posedge clk) begin
        if (s_fire) xmem[k_q] <= s.data;
        x_q <= $signed(xmem[xa]);
        if (wb) begin
            for (int l = 0; l < P; l++) ybuf[OW'(int'(g_q) * P + l)] <= res[l];
        end
    end

    for (genvar l = 0; l < P; l++) begin : g_lane
        fc_mac_lane #(
            .M(M), .N(N), .P(P), .T(T), .L(l), .RELU(RELU),
            .W_INIT(W_INIT), .B_INIT(B_INIT)
        ) u_lane (
            .clk(clk),
            .g(g_q),
            .j(xa),
            .x(x_q),
            .clr(clr),
            .en(en),
            .res(res[l])
        );
    end

endmodule

// File: tb/tb_fc_layer_par.sv
// Directed bench for fc_layer_par: vector table plus reset sequences.
// Five layer instances share one stimulus path selected by sel.
module tb_fc_layer_par;
    localparam int M  = 8;
    localparam int N  = 8;
    localparam int T  = 16;
    localparam int NI = 5;
    localparam int NV = 6;

    function automatic logic [M*N*T-1:0] w_ident();
        logic [M*N*T-1:0] w;
        w = '0;
        for (int r = 0; r < M; r++) w[(r*N+r)*T +: T] = 16'd1;
        return w;
    endfunction

    localparam logic [M*N*T-1:0] W_ID  = w_ident();
    localparam logic [M*N*T-1:0] W_SAT = {(M*N){16'h7fff}};

    typedef struct {
        int                 inst;
        logic [N-1:0][15:0] x;
        logic [M-1:0][15:0] y;
        int                 lat;
    } vec_t;

    vec_t tv [8];

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tb_valid = 1'b0;
    logic tb_ready = 1'b0;
    logic [15:0] tb_data = '0;
    logic [2:0] sel = '0;
    logic [NI-1:0] rdy_v, mv_v;
    logic [15:0] dout_v [NI];
    logic s_ready_s, m_valid_s;
    logic [15:0] dout_s;
    bit [3:0] pat = 4'b1001;
    int cyc = 0;
    int acc_cyc = 0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign s_ready_s = rdy_v[sel];
    assign m_valid_s = mv_v[sel];
    assign dout_s    = dout_v[sel];

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int PI = (i == 1) ? 2 : (i == 2) ? 4 : (i == 4) ? 2 : 1;
        fc_layer_par_if #(.T(T)) sb();
        fc_layer_par_if #(.T(T)) mb();
        assign sb.valid  = tb_valid && (sel == 3'(i));
        assign sb.data   = tb_data;
        assign mb.ready  = tb_ready && (sel == 3'(i));
        assign rdy_v[i]  = sb.ready;
        assign mv_v[i]   = mb.valid;
        assign dout_v[i] = mb.data;
        fc_layer_par #(
            .M(M), .N(N), .P(PI), .T(T), .RELU((i == 4) ? 0 : 1),
            .W_INIT((i < 3) ? W_ID : W_SAT), .B_INIT('0)
        ) dut (
            .clk(clk),
            .reset(reset),
            .s(sb),
            .m(mb)
        );
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int idx, input bit gaps);
        int w;
        for (int k = 0; k < N; k++) begin
            if (gaps) begin
                tb_valid = 1'b0;
                repeat ($urandom_range(0, 2)) step();
            end
            tb_valid = 1'b1;
            tb_data  = tv[idx].x[k];
            w = 0;
            while (!s_ready_s && w < 200) begin
                step();
                w++;
            end
            if (!s_ready_s) begin
                chk("s_ready_timeout", 0, 1);
                tb_valid = 1'b0;
                return;
            end
            step();
        end
        tb_valid = 1'b0;
        acc_cyc  = cyc;
        chk("s_ready_after_load", int'(s_ready_s), 0);
    endtask

    task automatic recv(input int idx, input bit bp, input int nw);
        int w;
        int got;
        bit r;
        w = 0;
        got = 0;
        tb_ready = 1'b0;
        while (!m_valid_s && w < 2000) begin
            step();
            w++;
        end
        if (!m_valid_s) begin
            chk("m_valid_timeout", 0, 1);
            return;
        end
        chk($sformatf("latency_v%0d", idx), cyc - acc_cyc, tv[idx].lat);
        while (got < nw && w < 4000) begin
            chk($sformatf("m_valid_v%0d_%0d", idx, got), int'(m_valid_s), 1);
            if (!m_valid_s) break;
            r = bp ? (pat[got % 4] ^ ($urandom_range(0, 3) == 0)) : 1'b1;
            tb_ready = r;
            chk($sformatf("y_v%0d_%0d", idx, got), int'(dout_s), int'(tv[idx].y[got]));
            step();
            w++;
            if (r) got++;
        end
        tb_ready = 1'b0;
        if (got < nw) chk("recv_count", got, nw);
        if (nw == M) begin
            chk("m_valid_done", int'(m_valid_s), 0);
            chk("s_ready_done", int'(s_ready_s), 1);
        end
    endtask

    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk({tag, "_m_valid"}, int'(m_valid_s), 0);
        chk({tag, "_s_ready"}, int'(s_ready_s), 0);
        chk({tag, "_data_out"}, int'(dout_s), 0);
        step();
        chk({tag, "_s_ready_up"}, int'(s_ready_s), 1);
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            tv[0].x[k] = 16'(k + 1);
            tv[0].y[k] = 16'(k + 1);
            tv[3].x[k] = 16'h7fff;
            tv[3].y[k] = 16'h7fff;
            tv[4].x[k] = 16'h8000;
            tv[4].y[k] = 16'h0000;
            tv[5].x[k] = 16'h8000;
            tv[5].y[k] = 16'h8000;
            tv[7].x[k] = 16'(N - k);
            tv[7].y[k] = 16'(N - k);
        end
        tv[0].inst = 0; tv[0].lat = 89;
        tv[1] = tv[0]; tv[1].inst = 1; tv[1].lat = 45;
        tv[2] = tv[0]; tv[2].inst = 2; tv[2].lat = 23;
        tv[3].inst = 3; tv[3].lat = 89;
        tv[4].inst = 3; tv[4].lat = 89;
        tv[5].inst = 4; tv[5].lat = 45;
        tv[6].inst = 0; tv[6].lat = 89;
        tv[6].x = {16'hff38, 16'h0064, 16'hffff, 16'h0000,
                   16'h7fff, 16'h8000, 16'h0003, 16'hfffb};
        tv[6].y = {16'h0000, 16'h0064, 16'h0000, 16'h0000,
                   16'h7fff, 16'h0000, 16'h0003, 16'h0000};
        tv[7].inst = 0; tv[7].lat = 89;

        reset = 1'b1;
        repeat (2) step();
        chk("rst_s_ready", int'(s_ready_s), 0);
        chk("rst_m_valid", int'(m_valid_s), 0);
        chk("rst_data_out", int'(dout_s), 0);
        reset = 1'b0;
        step();
        chk("s_ready_post_reset", int'(s_ready_s), 1);

        for (int i = 0; i < NV; i++) begin
            sel = 3'(tv[i].inst);
            send(i, (i % 2) == 1);
            recv(i, (i % 3) != 0, M);
        end

        sel = 3'd0;
        send(7, 1'b0);
        repeat (20) step();
        chk("compute_s_ready", int'(s_ready_s), 0);
        chk("compute_m_valid", int'(m_valid_s), 0);
        pulse_reset("rst_compute");
        send(6, 1'b1);
        recv(6, 1'b0, M);

        send(7, 1'b0);
        recv(7, 1'b0, 3);
        pulse_reset("rst_output");
        send(6, 1'b0);
        recv(6, 1'b1, M);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
